// File: rtl/alu_sequencer.sv
// Control sequencer for a simple 16-bit datapath: holds one instruction,
// walks it through register read, ALU and writeback steps, and drives strobes.
// Ports:
//   clk, reset (async, active-high)
//   load, in[15:0] : capture instruction (only while idle)
//   s              : start the held instruction
//   w              : idle/ready
//   err            : one-cycle pulse for an unsupported instruction
//   rnum, vsel, loada/b/c/s, asel, bsel, write, ALUop, shift, sximm8
//                  : datapath controls, all Moore (state + IR)
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  rnum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM
    } state_t;

    state_t      state, next;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    logic is_mov_imm, is_mov_reg, is_mvn, is_arith, is_cmp;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    // ADD, CMP, AND all need both operands
    assign is_arith   = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= next;
            if (state == WAIT && load)
                ir <= in;
        end
    end

    always_comb begin
        next  = state;
        w     = 1'b0;
        err   = 1'b0;
        rnum  = 3'd0;
        vsel  = 2'b00;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        write = 1'b0;
        ALUop = 2'b00;
        shift = 2'b00;
        unique case (state)
            WAIT: begin
                w = 1'b1;
                if (s)
                    next = DECODE;
            end
            DECODE: begin
                if (is_mov_imm)
                    next = WRITE_IMM;
                else if (is_mov_reg || is_mvn)
                    next = GET_B;
                else if (is_arith)
                    next = GET_A;
                else begin
                    // err is decoded here so it lasts exactly this one cycle
                    err  = 1'b1;
                    next = WAIT;
                end
            end
            GET_A: begin
                rnum  = rn;
                loada = 1'b1;
                next  = GET_B;
            end
            GET_B: begin
                rnum  = rm;
                loadb = 1'b1;
                next  = ALU;
            end
            ALU: begin
                shift = sh;
                if (is_mov_reg) begin
                    // MOV reg is computed as 0 + shifted Rm
                    ALUop = 2'b00;
                    asel  = 1'b1;
                end else begin
                    ALUop = op;
                end
                if (is_cmp) begin
                    loads = 1'b1;
                    next  = WAIT;
                end else begin
                    loadc = 1'b1;
                    next  = WRITE_REG;
                end
            end
            WRITE_REG: begin
                rnum  = rd;
                vsel  = 2'b00;
                write = 1'b1;
                next  = WAIT;
            end
            WRITE_IMM: begin
                rnum  = rn;
                vsel  = 2'b10;
                write = 1'b1;
                next  = WAIT;
            end
            default: next = WAIT;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: walks each instruction class
// state by state and compares all control outputs.
module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        load;
    logic        s;
    logic [15:0] in;
    logic        w, err;
    logic [2:0]  rnum;
    logic [1:0]  vsel;
    logic        loada, loadb, loadc, loads;
    logic        asel, bsel, write;
    logic [1:0]  ALUop, shift;
    logic [15:0] sximm8;

    int errors = 0;
    int checks = 0;

    alu_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .s      (s),
        .in     (in),
        .w      (w),
        .err    (err),
        .rnum   (rnum),
        .vsel   (vsel),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .asel   (asel),
        .bsel   (bsel),
        .write  (write),
        .ALUop  (ALUop),
        .shift  (shift),
        .sximm8 (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected control bundle; bsel is always 0
    function automatic logic [17:0] mk(
        input logic       ew,
        input logic       eerr,
        input logic [2:0] ernum,
        input logic [1:0] evsel,
        input logic       ela,
        input logic       elb,
        input logic       elc,
        input logic       els,
        input logic       easel,
        input logic       ewr,
        input logic [1:0] eop,
        input logic [1:0] esh
    );
        return {ew, eerr, ernum, evsel, ela, elb, elc, els,
                easel, 1'b0, ewr, eop, esh};
    endfunction

    localparam logic [17:0] IDLE = 18'h20000;
    localparam logic [17:0] ZERO = 18'h00000;

    task automatic chk(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = {w, err, rnum, vsel, loada, loadb, loadc, loads,
               asel, bsel, write, ALUop, shift};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkx(input string tag, input logic [15:0] exp);
        checks++;
        assert (sximm8 === exp) else begin
            errors++;
            $error("FAIL %s: sximm8 got %h expected %h", tag, sximm8, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // load the word while idle, then pulse s; returns in DECODE
    task automatic start(input logic [15:0] ins);
        load = 1'b1;
        in   = ins;
        tick();
        load = 1'b0;
        s    = 1'b1;
        tick();
        s    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        s     = 1'b0;
        in    = 16'h0000;
        tick();
        chk("rst_hold", IDLE);
        chkx("rst_ir", 16'h0000);
        reset = 1'b0;
        tick();
        chk("idle", IDLE);

        // MOV R0,#7
        start(16'hD007);
        chk("movi_dec", ZERO);
        tick();
        chk("movi_wimm", mk(0,0,3'd0,2'b10,0,0,0,0,0,1,2'b00,2'b00));
        chkx("movi_sx", 16'h0007);
        tick();
        chk("movi_done", IDLE);

        // MOV R0,#-7
        start(16'hD0F9);
        tick();
        chk("movn_wimm", mk(0,0,3'd0,2'b10,0,0,0,0,0,1,2'b00,2'b00));
        chkx("movn_sx", 16'hFFF9);
        tick();
        chk("movn_done", IDLE);

        // ADD R2,R1,R0,LSL#1
        start(16'hA148);
        chk("add_dec", ZERO);
        tick();
        chk("add_geta", mk(0,0,3'd1,2'b00,1,0,0,0,0,0,2'b00,2'b00));
        tick();
        chk("add_getb", mk(0,0,3'd0,2'b00,0,1,0,0,0,0,2'b00,2'b00));
        tick();
        chk("add_alu", mk(0,0,3'd0,2'b00,0,0,1,0,0,0,2'b00,2'b01));
        tick();
        chk("add_wreg", mk(0,0,3'd2,2'b00,0,0,0,0,0,1,2'b00,2'b00));
        tick();
        chk("add_done", IDLE);

        // CMP R1,R0 with s/load noise while busy
        start(16'hA900);
        chk("cmp_dec", ZERO);
        tick();
        chk("cmp_geta", mk(0,0,3'd1,2'b00,1,0,0,0,0,0,2'b00,2'b00));
        tick();
        chk("cmp_getb", mk(0,0,3'd0,2'b00,0,1,0,0,0,0,2'b00,2'b00));
        s    = 1'b1;
        load = 1'b1;
        in   = 16'hD0F9;
        tick();
        chk("cmp_alu", mk(0,0,3'd0,2'b00,0,0,0,1,0,0,2'b01,2'b00));
        s    = 1'b0;
        load = 1'b0;
        tick();
        chk("cmp_done", IDLE);
        tick();
        chk("cmp_no_queue", IDLE);
        // re-run without load: IR must still hold the CMP
        s = 1'b1;
        tick();
        s = 1'b0;
        chk("cmp2_dec", ZERO);
        tick();
        chk("cmp2_geta", mk(0,0,3'd1,2'b00,1,0,0,0,0,0,2'b00,2'b00));
        tick();
        tick();
        chk("cmp2_alu", mk(0,0,3'd0,2'b00,0,0,0,1,0,0,2'b01,2'b00));
        tick();
        chk("cmp2_done", IDLE);

        // MOV R1,R0
        start(16'hC020);
        chk("movr_dec", ZERO);
        tick();
        chk("movr_getb", mk(0,0,3'd0,2'b00,0,1,0,0,0,0,2'b00,2'b00));
        tick();
        chk("movr_alu", mk(0,0,3'd0,2'b00,0,0,1,0,1,0,2'b00,2'b00));
        tick();
        chk("movr_wreg", mk(0,0,3'd1,2'b00,0,0,0,0,0,1,2'b00,2'b00));
        tick();
        chk("movr_done", IDLE);

        // MVN R3,R0
        start(16'hB860);
        tick();
        chk("mvn_getb", mk(0,0,3'd0,2'b00,0,1,0,0,0,0,2'b00,2'b00));
        tick();
        chk("mvn_alu", mk(0,0,3'd0,2'b00,0,0,1,0,0,0,2'b11,2'b00));
        tick();
        chk("mvn_wreg", mk(0,0,3'd3,2'b00,0,0,0,0,0,1,2'b00,2'b00));
        tick();
        chk("mvn_done", IDLE);

        // unsupported opcode
        start(16'hE000);
        chk("bad_dec", mk(0,1,3'd0,2'b00,0,0,0,0,0,0,2'b00,2'b00));
        tick();
        chk("bad_done", IDLE);
        tick();
        chk("bad_idle", IDLE);

        // async reset in GET_B of an ADD
        start(16'hA148);
        tick();
        tick();
        chk("rst_getb", mk(0,0,3'd0,2'b00,0,1,0,0,0,0,2'b00,2'b00));
        #2 reset = 1'b1;
        #1;
        chk("rst_async", IDLE);
        chkx("rst_async_ir", 16'h0000);
        @(posedge clk);
        #1;
        chk("rst_held", IDLE);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_resume", IDLE);
        // IR cleared to 0x0000 decodes as unsupported
        s = 1'b1;
        tick();
        s = 1'b0;
        chk("rst_ir_err", mk(0,1,3'd0,2'b00,0,0,0,0,0,0,2'b00,2'b00));
        tick();
        chk("rst_final", IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have port clk (input, 1): single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset (input, 1): asynchronous, active-high reset.
REQ-003 The block SHALL have port load (input, 1): instruction register capture enable.
REQ-004 The block SHALL have port s (input, 1): start request for the held instruction.
REQ-005 The block SHALL have port in (input, 16): instruction word.
REQ-006 The block SHALL have port w (output, 1): idle/ready flag.
REQ-007 The block SHALL have port err (output, 1): one-cycle unsupported-instruction pulse.
REQ-008 The block SHALL have port rnum (output, 3): register file read/write index.
REQ-009 The block SHALL have port vsel (output, 2): writeback source select; 00 = ALU result C, 10 = sximm8.
REQ-010 The block SHALL have ports loada, loadb, loadc, loads (output, 1 each): A, B, C and status register load strobes.
REQ-011 The block SHALL have ports asel, bsel (output, 1 each): asel=1 forces ALU Ain to 0; bsel is always 0 from this block.
REQ-012 The block SHALL have port write (output, 1): register file write enable.
REQ-013 The block SHALL have port ALUop (output, 2): ALU operation; 00 add, 01 sub, 10 and, 11 not-B.
REQ-014 The block SHALL have port shift (output, 2): shifter control, taken from IR[4:3].
REQ-015 The block SHALL have port sximm8 (output, 16): IR[7:0] sign-extended to 16 bits.

Function
REQ-016 The internal 16-bit IR SHALL capture in on a rising edge with load=1 while in WAIT; load SHALL be ignored in all other states.
REQ-017 Instruction fields SHALL be: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
REQ-018 The FSM SHALL have states WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM; all outputs SHALL be Moore, decoded from state and IR only.
REQ-019 In WAIT with s=1 at a rising edge, the FSM SHALL go to DECODE; with s=0 it SHALL stay in WAIT.
REQ-020 From DECODE the FSM SHALL go to WRITE_IMM for opcode 110/op 10, to GET_B for 110/00 and 101/11, to GET_A for 101/00, 101/01 and 101/10, and to WAIT with err=1 for one cycle otherwise.
REQ-021 In GET_A the block SHALL drive rnum=Rn and loada=1, then go to GET_B.
REQ-022 In GET_B the block SHALL drive rnum=Rm and loadb=1, then go to ALU.
REQ-023 In ALU the block SHALL drive ALUop=op and shift=sh; for 110/00 it SHALL force ALUop=00 and asel=1.
REQ-024 In ALU the block SHALL drive loads=1 and loadc=0 for CMP (101/01) and go to WAIT; for all other operations it SHALL drive loadc=1 and go to WRITE_REG.
REQ-025 In WRITE_REG the block SHALL drive rnum=Rd, vsel=00 and write=1, then go to WAIT.
REQ-026 In WRITE_IMM the block SHALL drive rnum=Rn, vsel=10 and write=1, then go to WAIT.
REQ-027 w SHALL be 1 only in WAIT.
REQ-028 Every strobe not explicitly driven in a state SHALL be 0; rnum, ALUop, shift and vsel SHALL be 0 when not specified.
REQ-029 Cycles from the s edge back to WAIT SHALL be: MOV imm 2; MOV reg 4; MVN 4; CMP 4; ADD/AND 5; unsupported 1.
REQ-030 While the FSM is not in WAIT, s SHALL be ignored; no queuing of start requests.

Reset
REQ-031 Assertion of reset SHALL immediately, without waiting for clk, put the FSM in WAIT and clear IR to 0x0000, including mid-instruction.
REQ-032 While reset is held, outputs SHALL be w=1 and all other outputs 0, with no write strobe issued after reset asserts.
REQ-033 Operation SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-034 The bench SHALL load 0xD007, pulse s -> DECODE, then WRITE_IMM with rnum=0, vsel=10, write=1, sximm8=0x0007; w=1 on the next cycle.
REQ-035 The bench SHALL load 0xD0F9 -> sximm8=0xFFF9 in WRITE_IMM.
REQ-036 The bench SHALL load 0xA148 (ADD R2,R1,R0,LSL#1) -> GET_A rnum=1 loada; GET_B rnum=0 loadb; ALU ALUop=00 shift=01 loadc; WRITE_REG rnum=2 write; 5 cycles total.
REQ-037 The bench SHALL load 0xA900 (CMP R1,R0) -> ALU state has loads=1, loadc=0, ALUop=01; no write at any cycle; WAIT after 4 cycles.
REQ-038 The bench SHALL load 0xC020 (MOV R1,R0) -> GET_B rnum=0; ALU asel=1, ALUop=00; WRITE_REG rnum=1. Loading 0xB860 (MVN) -> ALUop=11, WRITE_REG rnum=3.
REQ-039 The bench SHALL load 0xE000, pulse s -> err=1 for exactly one cycle, no strobes. Then start 0xA148 and assert reset during GET_B -> immediate WAIT, w=1, IR=0, no write.
